// File: rtl/imem_port_arbiter_pkg.sv
// Shared definitions for the instruction-memory port arbiter.
package imem_port_arbiter_pkg;

   typedef logic [31:0] int_t;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      LOAD  = 2'd2
   } imem_arb_state_t;

   localparam int unsigned IMEM_WORDS = 1024;

endpackage

// File: rtl/imem_port_arbiter_if.sv
// Fetch/loader bus for imem_port_arbiter.
// Optional macro IMEM_LOAD_CHECKSUM_EN adds loadChecksum.
interface imem_port_arbiter_if;
   import imem_port_arbiter_pkg::*;

   logic        fetchValid;
   int_t        fetchAddress;
   logic        fetchGrant;
   logic        fetchDataValid;
   logic [31:0] fetchData;
   logic        loadValid;
   logic [31:0] loadAddress;
   logic [31:0] loadData;
   logic        loadReady;
   logic        loadMode;
   logic        cpuStall;
   logic        loadModeActive;
`ifdef IMEM_LOAD_CHECKSUM_EN
   logic [31:0] loadChecksum;

   modport master (
      output fetchValid, fetchAddress, loadValid, loadAddress, loadData, loadMode,
      input  fetchGrant, fetchDataValid, fetchData, loadReady, cpuStall, loadModeActive,
      input  loadChecksum
   );
   modport slave (
      input  fetchValid, fetchAddress, loadValid, loadAddress, loadData, loadMode,
      output fetchGrant, fetchDataValid, fetchData, loadReady, cpuStall, loadModeActive,
      output loadChecksum
   );
`else
   modport master (
      output fetchValid, fetchAddress, loadValid, loadAddress, loadData, loadMode,
      input  fetchGrant, fetchDataValid, fetchData, loadReady, cpuStall, loadModeActive
   );
   modport slave (
      input  fetchValid, fetchAddress, loadValid, loadAddress, loadData, loadMode,
      output fetchGrant, fetchDataValid, fetchData, loadReady, cpuStall, loadModeActive
   );
`endif

endinterface

// File: rtl/imem_port_arbiter_ram.sv
// Single-port instruction RAM: write commits at the edge, read is registered.
module imem_sync_ram
   import imem_port_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_WORDS = IMEM_WORDS,
   localparam int unsigned AW = $clog2(ADDR_WORDS)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          we,
   input  logic          re,
   input  logic [AW-1:0] addr,
   input  int_t          wdata,
   output int_t          rdata
);

   logic [31:0] mem [ADDR_WORDS];

   // Storage write; contents survive reset.
   always_ff @(posedge clock) begin
      if (we) mem[addr] <= wdata;
   end

   // Registered read port; output register cleared by reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)   rdata <= '0;
      else if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/imem_port_arbiter.sv
// Arbitrates one instruction RAM between CPU fetch and a loader port.
// Optional macro IMEM_LOAD_CHECKSUM_EN adds a running sum of LOAD-mode writes.
module imem_port_arbiter
   import imem_port_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_WORDS = IMEM_WORDS,
   parameter int unsigned MAX_STARVE = 4
) (
   input logic               clock,
   input logic               reset,
   imem_port_arbiter_if.slave bus
);

   localparam int unsigned AW          = $clog2(ADDR_WORDS);
   localparam logic [3:0]  STARVE_LAST = 4'(MAX_STARVE - 1);

   imem_arb_state_t state, state_next;
   logic [3:0]      starve, starve_next;
   logic            fetch_grant, load_ready, cpu_stall, load_mode_active;
   logic            fetch_pending;
   logic [AW-1:0]   ram_addr;

   // State, starvation counter and read-valid tracking.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= RUN;
         starve        <= '0;
         fetch_pending <= 1'b0;
      end else begin
         state         <= state_next;
         starve        <= starve_next;
         fetch_pending <= fetch_grant;
      end
   end

   // Grant selection and mode sequencing; reset suppresses every grant.
   always_comb begin
      state_next       = state;
      starve_next      = starve;
      fetch_grant      = 1'b0;
      load_ready       = 1'b0;
      cpu_stall        = 1'b0;
      load_mode_active = 1'b0;
      if (!reset) begin
         case (state)
            RUN: begin
               if (bus.fetchValid && bus.loadValid) begin
                  if (starve >= STARVE_LAST) begin
                     load_ready  = 1'b1;
                     starve_next = '0;
                  end else begin
                     fetch_grant = 1'b1;
                     starve_next = starve + 4'd1;
                  end
               end else if (bus.fetchValid) begin
                  fetch_grant = 1'b1;
               end else if (bus.loadValid) begin
                  load_ready  = 1'b1;
                  starve_next = '0;
               end
               cpu_stall = bus.fetchValid && !fetch_grant;
               if (bus.loadMode) state_next = DRAIN;
            end
            DRAIN: begin
               cpu_stall  = 1'b1;
               state_next = LOAD;
            end
            LOAD: begin
               load_ready       = bus.loadValid;
               cpu_stall        = 1'b1;
               load_mode_active = 1'b1;
               if (!bus.loadMode) begin
                  state_next  = RUN;
                  starve_next = '0;
               end
            end
            default: state_next = RUN;
         endcase
      end
   end

   // Writer owns the single RAM port whenever it is granted.
   always_comb begin
      ram_addr = load_ready ? bus.loadAddress[AW+1:2] : bus.fetchAddress[AW+1:2];
   end

   imem_sync_ram #(.ADDR_WORDS(ADDR_WORDS)) u_ram (
      .clock (clock),
      .reset (reset),
      .we    (load_ready),
      .re    (fetch_grant),
      .addr  (ram_addr),
      .wdata (bus.loadData),
      .rdata (bus.fetchData)
   );

   assign bus.fetchGrant     = fetch_grant;
   assign bus.fetchDataValid = fetch_pending;
   assign bus.loadReady      = load_ready;
   assign bus.cpuStall       = cpu_stall;
   assign bus.loadModeActive = load_mode_active;

`ifdef IMEM_LOAD_CHECKSUM_EN
   logic [31:0] checksum;

   // Sum of LOAD-mode writes, cleared on the DRAIN->LOAD edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)                            checksum <= '0;
      else if (state == DRAIN)              checksum <= '0;
      else if (state == LOAD && load_ready) checksum <= checksum + bus.loadData;
   end

   assign bus.loadChecksum = checksum;
`endif

endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares one single-ported, synchronous-read instruction RAM (1024 x 32-bit words) between two requesters: the CPU fetch stage and a program-load/debug port.
- Sits between the fetch stage and the instruction storage.
- Fetch has priority in normal running. A starvation counter guarantees the loader forward progress.
- An exclusive load mode drains outstanding fetches and then gives the loader the whole RAM while the CPU is stalled.

Parameters:
- ADDR_WORDS, 1024, RAM depth in words. Must be a power of two. Word index = address[log2(ADDR_WORDS)+1:2].
- MAX_STARVE, 4, consecutive contended cycles the loader may lose before it is granted once (range 1..15).

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- fetchValid  input  1  CPU requests a read
- fetchAddress  input  32 (int_t)  byte address; bits [1:0] ignored
- fetchGrant  output  1  fetch request accepted this cycle
- fetchDataValid  output  1  read data valid (one cycle after the grant)
- fetchData  output  32  raw instruction word; the consumer applies parseInstruction
- loadValid  input  1  loader requests a write
- loadAddress  input  32  byte address; bits [1:0] ignored
- loadData  input  32  word to write
- loadReady  output  1  write accepted this cycle
- loadMode  input  1  request exclusive load mode
- cpuStall  output  1  CPU must hold its PC
- loadModeActive  output  1  FSM is in LOAD

Behaviour:
- Reset values: all outputs 0; FSM = RUN; starve counter = 0; RAM contents unaffected.
- RAM access: one access per cycle.
  - Read is registered: data is valid the cycle after the grant.
  - Write commits at the clock edge of the grant.
- Address aliasing: out-of-range addresses alias modulo ADDR_WORDS. There is no error output.
- FSM states: RUN, DRAIN, LOAD.
- RUN:
  - fetch only -> fetchGrant=1.
  - load only -> loadReady=1, starve=0.
  - Both requesting and starve<MAX_STARVE-1 -> fetch granted, starve++.
  - Both requesting and starve==MAX_STARVE-1 -> load granted, starve=0. cpuStall=1 that cycle.
  - Neither requesting -> starve holds.
  - cpuStall = fetchValid && !fetchGrant.
  - loadMode=1 -> go to DRAIN. A fetch may still be granted in the transition cycle.
- DRAIN:
  - No grants. cpuStall=1.
  - The data from a fetch granted in the previous cycle is still delivered (fetchDataValid=1).
  - Next state is LOAD, unconditionally after 1 cycle.
- LOAD:
  - loadReady = loadValid. fetchGrant=0. cpuStall=1. loadModeActive=1.
  - loadMode=0 -> RUN next cycle, starve=0.
  - A write accepted in the exit cycle still commits.
- Invariants:
  - fetchGrant and loadReady are never both 1.
  - fetchDataValid pulses exactly one cycle after each fetchGrant.
- Mid-operation reset: the FSM returns to RUN immediately. A pending fetchDataValid is cleared and no stale data is flagged. A write already committed is kept.
- loadMode toggled while in DRAIN: LOAD is still entered, then exited on the next cycle if loadMode=0.

Optional Feature:
- IMEM_LOAD_CHECKSUM_EN defined:
  - Adds output port loadChecksum (32-bit), the modulo-2^32 sum of every loadData accepted while in LOAD.
  - Cleared to 0 on reset and on the cycle of entry into LOAD.
  - Held after exit.
  - Writes granted in RUN via starvation are not summed.
- Not defined: the port and the adder are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package/Definitions.sv:
  - int_t (already present)
  - imem_arb_state_t enum {RUN, DRAIN, LOAD}
  - IMEM_WORDS=1024 constant
- Natural sub-module: imem_sync_ram. Single-port, one write enable, registered read, depth ADDR_WORDS. The arbiter instantiates it.

Test Plan:
- Fetch only: fetchAddress=0x10 with RAM[4]=0xDEADBEEF -> fetchGrant same cycle; fetchData=0xDEADBEEF with fetchDataValid next cycle.
- Contention, MAX_STARVE=4: fetchValid and loadValid held high -> grant pattern F,F,F,L repeating; cpuStall=1 only in L cycles; loaded word readable afterwards.
- Load mode: loadMode rises while a fetch is granted -> DRAIN cycle delivers that fetch's data; LOAD next cycle; write 0x12345678 to 0x7FC, loadMode=0, fetch 0x7FC -> 0x12345678.
- Aliasing: write 0xCAFEF00D to 0x1004 in LOAD -> fetch 0x0004 returns 0xCAFEF00D.
- Reset mid-LOAD and cycle after fetch grant -> FSM=RUN, fetchDataValid=0, loadReady=0, cpuStall=0.
- With IMEM_LOAD_CHECKSUM_EN: load 1, 2, 0xFFFFFFFF in LOAD -> loadChecksum=0x00000002; re-entering LOAD clears it to 0.
